// File: rtl/ulpi_link_reg.sv
// Link-side ULPI engine: PHY register reads/writes (immediate and extended),
// bus turnaround, abort with retry, and RX CMD / RX data decode.
module ulpi_link_reg (
  input  logic       ulpi_clk,
  input  logic       ulpi_rst,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_stp,
  input  logic       reg_req,
  input  logic       reg_we,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic       reg_busy,
  output logic       reg_done,
  output logic [7:0] reg_rdata,
  output logic [1:0] line_state,
  output logic [1:0] vbus_state,
  output logic       rx_active,
  output logic       rx_error,
  output logic       host_disconnect,
  output logic       rx_cmd_valid,
  output logic [7:0] rx_data,
  output logic       rx_data_valid
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_EADDR   = 3'd2,
    ST_WDATA   = 3'd3,
    ST_STP     = 3'd4,
    ST_RD_TA   = 3'd5,
    ST_RD_DATA = 3'd6,
    ST_ABORT   = 3'd7
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic       dir_r;
  logic       turnaround_s;
  logic       accept_s;
  logic       read_pending_s;
  logic       rx_byte_s;
  logic       we_r;
  logic       we_s;
  logic [7:0] addr_r;
  logic [7:0] addr_s;
  logic [7:0] wdata_r;
  logic [7:0] wdata_s;
  logic [7:0] data_r;
  logic [7:0] data_s;
  logic       stp_s;
  logic       done_s;
  logic       busy_s;
  logic       capture_s;

  // Addresses outside the 6-bit immediate space, plus 0x2F itself, need the extended form.
  function automatic logic is_ext(input logic [7:0] addr);
    return (addr[7:6] != 2'b00) || (addr[5:0] == 6'h2F);
  endfunction

  function automatic logic [7:0] tx_cmd(input logic we, input logic [7:0] addr);
    logic [7:0] cmd;
    if (is_ext(addr)) begin
      cmd = we ? 8'hAF : 8'hEF;
    end else begin
      cmd = we ? {2'b10, addr[5:0]} : {2'b11, addr[5:0]};
    end
    return cmd;
  endfunction

  // dir_r resets high so the first dir-low cycle after reset counts as turnaround.
  assign turnaround_s   = (ulpi_dir != dir_r);
  assign accept_s       = reg_req && !ulpi_dir && !turnaround_s;
  assign read_pending_s = (state_r == ST_RD_TA) || (state_r == ST_RD_DATA);
  assign rx_byte_s      = ulpi_dir && !turnaround_s && !read_pending_s;
  assign ulpi_data_out  = (ulpi_dir || turnaround_s) ? 8'h00 : data_r;

  // Request latch: capture a new request only when it is accepted in IDLE.
  always_comb begin
    we_s    = we_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    if ((state_r == ST_IDLE) && accept_s) begin
      we_s    = reg_we;
      addr_s  = reg_addr;
      wdata_s = reg_wdata;
    end else begin
      we_s    = we_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;
    end
  end

  // State register.
  always_ff @(posedge ulpi_clk or posedge ulpi_rst) begin
    if (ulpi_rst) begin
      state_r <= ST_IDLE;
      dir_r   <= 1'b1;
      we_r    <= 1'b0;
      addr_r  <= 8'h00;
      wdata_r <= 8'h00;
    end else begin
      state_r <= state_s;
      dir_r   <= ulpi_dir;
      we_r    <= we_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
    end
  end

  // Next-state logic; dir seen high while the link is transmitting means the PHY aborted.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_CMD;
        else          state_s = ST_IDLE;
      end
      ST_CMD: begin
        if (ulpi_dir)                state_s = ST_ABORT;
        else if (!ulpi_nxt)          state_s = ST_CMD;
        else if (is_ext(addr_r))     state_s = ST_EADDR;
        else if (we_r)               state_s = ST_WDATA;
        else                         state_s = ST_RD_TA;
      end
      ST_EADDR: begin
        if (ulpi_dir)       state_s = ST_ABORT;
        else if (!ulpi_nxt) state_s = ST_EADDR;
        else if (we_r)      state_s = ST_WDATA;
        else                state_s = ST_RD_TA;
      end
      ST_WDATA: begin
        if (ulpi_dir)      state_s = ST_ABORT;
        else if (ulpi_nxt) state_s = ST_STP;
        else               state_s = ST_WDATA;
      end
      ST_STP: begin
        state_s = ST_IDLE;
      end
      ST_RD_TA: begin
        if (ulpi_dir && turnaround_s) state_s = ulpi_nxt ? ST_ABORT : ST_RD_DATA;
        else                          state_s = ST_RD_TA;
      end
      ST_RD_DATA: begin
        state_s = ST_IDLE;
      end
      ST_ABORT: begin
        if (!ulpi_dir && !turnaround_s) state_s = ST_CMD;
        else                            state_s = ST_ABORT;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it.
  always_comb begin
    data_s = 8'h00;
    case (state_s)
      ST_CMD:   data_s = tx_cmd(we_s, addr_s);
      ST_EADDR: data_s = addr_s;
      ST_WDATA: data_s = wdata_s;
      default:  data_s = 8'h00;
    endcase
    stp_s     = (state_s == ST_STP);
    busy_s    = (state_s != ST_IDLE);
    done_s    = (state_r == ST_STP) || (state_r == ST_RD_DATA);
    capture_s = (state_r == ST_RD_DATA);
  end

  // Register-access side outputs.
  always_ff @(posedge ulpi_clk or posedge ulpi_rst) begin
    if (ulpi_rst) begin
      data_r    <= 8'h00;
      ulpi_stp  <= 1'b0;
      reg_busy  <= 1'b0;
      reg_done  <= 1'b0;
      reg_rdata <= 8'h00;
    end else begin
      data_r   <= data_s;
      ulpi_stp <= stp_s;
      reg_busy <= busy_s;
      reg_done <= done_s;
      if (capture_s) reg_rdata <= ulpi_data_in;
    end
  end

  // RX CMD and RX data decode; the byte of a pending register read is not decoded.
  always_ff @(posedge ulpi_clk or posedge ulpi_rst) begin
    if (ulpi_rst) begin
      line_state      <= 2'b00;
      vbus_state      <= 2'b00;
      rx_active       <= 1'b0;
      rx_error        <= 1'b0;
      host_disconnect <= 1'b0;
      rx_cmd_valid    <= 1'b0;
      rx_data         <= 8'h00;
      rx_data_valid   <= 1'b0;
    end else begin
      rx_cmd_valid  <= rx_byte_s && !ulpi_nxt;
      rx_data_valid <= rx_byte_s && ulpi_nxt;
      if (rx_byte_s && !ulpi_nxt) begin
        line_state      <= ulpi_data_in[1:0];
        vbus_state      <= ulpi_data_in[3:2];
        rx_active       <= (ulpi_data_in[5:4] == 2'b01);
        rx_error        <= (ulpi_data_in[5:4] == 2'b11);
        host_disconnect <= (ulpi_data_in[5:4] == 2'b10);
      end
      if (rx_byte_s && ulpi_nxt) rx_data <= ulpi_data_in;
    end
  end

endmodule
